// File: rtl/parc_dmem_responder.sv
// Data-memory responder. Accepts one val/rdy request at a time, performs a word or
// subword access on an internal array, and answers after LATENCY extra cycles.
module parc_dmem_responder #(
    parameter int NUM_WORDS = 1024,
    parameter int LATENCY   = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        memreq_val,
    output logic        memreq_rdy,
    input  logic        memreq_msg_type,
    input  logic [31:0] memreq_msg_addr,
    input  logic [1:0]  memreq_msg_len,
    input  logic [31:0] memreq_msg_data,

    output logic        memresp_val,
    input  logic        memresp_rdy,
    output logic        memresp_msg_type,
    output logic [1:0]  memresp_msg_len,
    output logic [31:0] memresp_msg_data
);

    localparam int AW = $clog2(NUM_WORDS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [3:0]    count;
    logic [3:0]    count_next;
    logic          accept;

    logic [AW-1:0] word_idx;
    logic [1:0]    off;
    logic [4:0]    shamt;
    logic [3:0]    len_mask;
    logic [31:0]   read_mask;
    logic [3:0]    write_be;
    logic [31:0]   write_data;
    logic [31:0]   read_data;

    logic [31:0]   mem [NUM_WORDS];

    logic          unused_addr_bits;
    assign unused_addr_bits = &{1'b0, memreq_msg_addr[31:AW+2]};

    // Ready depends only on state and the response handshake, never on memreq_val.
    assign memreq_rdy  = (state == IDLE) | ((state == RESP) & memresp_rdy);
    assign accept      = memreq_val & memreq_rdy;
    assign memresp_val = (state == RESP);

    assign word_idx = memreq_msg_addr[AW+1:2];
    assign off      = memreq_msg_addr[1:0];
    assign shamt    = {off, 3'b000};

    always_comb begin
        case (memreq_msg_len)
            2'd1:    len_mask = 4'b0001;
            2'd2:    len_mask = 4'b0011;
            2'd3:    len_mask = 4'b0111;
            default: len_mask = 4'b1111;
        endcase
    end

    always_comb begin
        read_mask = 32'h0;
        for (int b = 0; b < 4; b++) begin
            read_mask[8*b +: 8] = {8{len_mask[b]}};
        end
    end

    // Shifting toward lane 3 truncates, so bytes past the word boundary are dropped.
    assign write_be   = len_mask << off;
    assign write_data = memreq_msg_data << shamt;
    assign read_data  = (mem[word_idx] >> shamt) & read_mask;

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    state_next = (LATENCY > 0) ? WAIT : RESP;
                    count_next = LAT_LOAD;
                end else if ((state == RESP) && memresp_rdy) begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (count == 4'd0) begin
                    state_next = RESP;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            count            <= 4'd0;
            memresp_msg_type <= 1'b0;
            memresp_msg_len  <= 2'd0;
            memresp_msg_data <= 32'h0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (accept) begin
                memresp_msg_type <= memreq_msg_type;
                memresp_msg_len  <= memreq_msg_len;
                memresp_msg_data <= memreq_msg_type ? 32'h0 : read_data;
            end
        end
    end

    // The array itself is never cleared; writes survive a reset.
    always_ff @(posedge clk) begin
        if (!reset && accept && memreq_msg_type) begin
            for (int b = 0; b < 4; b++) begin
                if (write_be[b]) begin
                    mem[word_idx][8*b +: 8] <= write_data[8*b +: 8];
                end
            end
        end
    end

endmodule
